// File: rtl/swap_scheduler_if.sv
// rtl/swap_scheduler_if.sv - Requester, completion and register-file signals of swap_scheduler
interface swap_scheduler_if #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  s0_valid;
  logic                  s0_ready;
  logic [ADDR_WIDTH-1:0] s0_addr_a;
  logic [ADDR_WIDTH-1:0] s0_addr_b;
  logic                  s1_valid;
  logic                  s1_ready;
  logic [ADDR_WIDTH-1:0] s1_addr_a;
  logic [ADDR_WIDTH-1:0] s1_addr_b;
  logic                  done;
  logic                  done_id;
  logic                  done_err;
  logic                  rf_we;
  logic [ADDR_WIDTH-1:0] rf_address_w;
  logic [DATA_WIDTH-1:0] rf_data_w;
  logic                  rf_swap;
  logic [ADDR_WIDTH-1:0] rf_address_A;
  logic [ADDR_WIDTH-1:0] rf_address_B;
  logic                  busy;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output s0_valid, s0_addr_a, s0_addr_b,
    output s1_valid, s1_addr_a, s1_addr_b,
    input  wr_ready, s0_ready, s1_ready,
    input  done, done_id, done_err,
    input  rf_we, rf_address_w, rf_data_w, rf_swap, rf_address_A, rf_address_B, busy
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  s0_valid, s0_addr_a, s0_addr_b,
    input  s1_valid, s1_addr_a, s1_addr_b,
    output wr_ready, s0_ready, s1_ready,
    output done, done_id, done_err,
    output rf_we, rf_address_w, rf_data_w, rf_swap, rf_address_A, rf_address_B, busy
  );
endinterface

// File: rtl/swap_scheduler.sv
// rtl/swap_scheduler.sv - Round-robin sequencer for one host write channel and two swap requesters
// Optional SWAP_SCHED_PERF_EN adds saturating swap_count/err_count outputs.
module swap_scheduler #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int SWAP_LAT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  swap_scheduler_if.slave  bus
`ifdef SWAP_SCHED_PERF_EN
  ,
  output logic [15:0]      swap_count,
  output logic [7:0]       err_count
`endif
);

  generate
    if (SWAP_LAT < 2 || SWAP_LAT > 15) begin : g_bad_lat
      $error("swap_scheduler: SWAP_LAT must be within 2..15");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, WRITE, ISSUE, BUSY, DONE} state_t;

  localparam logic [1:0] REQ_W  = 2'd0;
  localparam logic [1:0] REQ_S1 = 2'd2;

  state_t                state;
  state_t                state_nxt;
  logic [1:0]            rr_ptr;
  logic [1:0]            gnt_idx;
  logic [1:0]            cand;
  logic [2:0]            idx_sum;
  logic [2:0]            req;
  logic                  gnt_any;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_a;
  logic [ADDR_WIDTH-1:0] sel_b;
  logic                  sel_legal;
  logic [3:0]            cnt;
  logic                  id_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [ADDR_WIDTH-1:0] b_q;

  assign req = {bus.s1_valid, bus.s0_valid, bus.wr_valid};

  // First valid requester at or after the pointer, walking W -> S0 -> S1 cyclically.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = rr_ptr;
    cand    = 2'd0;
    idx_sum = 3'd0;
    for (int i = 0; i < 3; i++) begin
      idx_sum = {1'b0, rr_ptr} + 3'(i);
      if (idx_sum >= 3'd3) idx_sum = idx_sum - 3'd3;
      cand = idx_sum[1:0];
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign accept = reset_n && (state == IDLE) && gnt_any;

  assign bus.wr_ready = accept && (gnt_idx == REQ_W);
  assign bus.s0_ready = accept && (gnt_idx == 2'd1);
  assign bus.s1_ready = accept && (gnt_idx == REQ_S1);

  assign sel_a = (gnt_idx == REQ_S1) ? bus.s1_addr_a : bus.s0_addr_a;
  assign sel_b = (gnt_idx == REQ_S1) ? bus.s1_addr_b : bus.s0_addr_b;
  // Address 0 is the engine's temporary slot, so it can never be a swap operand.
  assign sel_legal = (sel_a != sel_b) && (sel_a != '0) && (sel_b != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.rf_we    = 1'b0;
    bus.rf_swap  = 1'b0;
    bus.done     = 1'b0;
    bus.done_id  = 1'b0;
    bus.done_err = 1'b0;
    bus.busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (gnt_idx == REQ_W) state_nxt = WRITE;
          else if (sel_legal)   state_nxt = ISSUE;
          else                  state_nxt = DONE;
        end
      end
      WRITE: begin
        bus.rf_we = 1'b1;
        state_nxt = IDLE;
      end
      ISSUE: begin
        bus.rf_swap = 1'b1;
        state_nxt   = BUSY;
      end
      BUSY: begin
        if (cnt <= 4'd1) state_nxt = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        bus.done_id  = id_q;
        bus.done_err = err_q;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr  <= REQ_W;
      waddr_q <= '0;
      wdata_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (gnt_idx == REQ_S1) ? REQ_W : gnt_idx + 2'd1;
        if (gnt_idx == REQ_W) begin
          waddr_q <= bus.wr_addr;
          wdata_q <= bus.wr_data;
        end else begin
          id_q  <= (gnt_idx == REQ_S1);
          err_q <= !sel_legal;
          // Operands only change for a swap that will really be issued.
          if (sel_legal) begin
            a_q <= sel_a;
            b_q <= sel_b;
          end
        end
      end
      if (state == ISSUE)     cnt <= 4'(SWAP_LAT - 1);
      else if (state == BUSY) cnt <= cnt - 4'd1;
    end
  end

  assign bus.rf_address_w = waddr_q;
  assign bus.rf_data_w    = wdata_q;
  assign bus.rf_address_A = a_q;
  assign bus.rf_address_B = b_q;

`ifdef SWAP_SCHED_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      swap_count <= '0;
      err_count  <= '0;
    end else if (state == DONE) begin
      if (!err_q) begin
        if (swap_count != '1) swap_count <= swap_count + 16'd1;
      end else begin
        if (err_count != '1) err_count <= err_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_swap_scheduler.sv
// tb/tb_swap_scheduler.sv - Self-checking bench for swap_scheduler (vector table, corner sequences, random vs model)
module tb_swap_scheduler;
  localparam int AW  = 7;
  localparam int DW  = 8;
  localparam int LAT = 4;
  localparam int NR  = 600;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  swap_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

`ifdef SWAP_SCHED_PERF_EN
  logic [15:0] swap_count;
  logic [7:0]  err_count;
`endif

  swap_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SWAP_LAT(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef SWAP_SCHED_PERF_EN
    ,
    .swap_count (swap_count),
    .err_count  (err_count)
`endif
  );

  typedef struct {
    logic          wv, s0v, s1v;
    logic [AW-1:0] a, b, waddr;
    logic [DW-1:0] wdata;
    logic [2:0]    exp_rdy;
    logic          exp_we, exp_swap;
    int            exp_lat;
    logic          exp_err, exp_id;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  vec_t vecs[9];

  bit            e_we[1024], e_swap[1024], e_done[1024], e_busy[1024], e_id[1024], e_err[1024];
  logic [AW-1:0] ra[3], rb[3];
  logic [DW-1:0] rd[3];
  logic [2:0]    rv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic wv, s0v, s1v, input logic [AW-1:0] a, b, waddr,
                              input logic [DW-1:0] wdata, input logic [2:0] rdy,
                              input logic we, sw, input int lat, input logic err, id);
    vec_t v;
    v.wv = wv; v.s0v = s0v; v.s1v = s1v; v.a = a; v.b = b; v.waddr = waddr; v.wdata = wdata;
    v.exp_rdy = rdy; v.exp_we = we; v.exp_swap = sw; v.exp_lat = lat; v.exp_err = err; v.exp_id = id;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.wr_valid = 0; bus.s0_valid = 0; bus.s1_valid = 0;
    bus.wr_addr = '0; bus.wr_data = '0;
    bus.s0_addr_a = '0; bus.s0_addr_b = '0; bus.s1_addr_a = '0; bus.s1_addr_b = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  // Single request from IDLE; follows it to completion and checks timing and side effects.
  task automatic run_vec(input vec_t v);
    int got, extra, limit;
    logic gid, gerr;
    got = 0; extra = 0; gid = 0; gerr = 0;
    limit = (v.exp_lat == 0) ? 6 : 20;
    @(posedge clk); #1;
    bus.wr_valid = v.wv; bus.s0_valid = v.s0v; bus.s1_valid = v.s1v;
    bus.wr_addr = v.waddr; bus.wr_data = v.wdata;
    bus.s0_addr_a = v.a; bus.s0_addr_b = v.b; bus.s1_addr_a = v.a; bus.s1_addr_b = v.b;
    @(negedge clk);
    check("vec_ready", {bus.s1_ready, bus.s0_ready, bus.wr_ready}, v.exp_rdy);
    @(posedge clk); #1;
    bus.wr_valid = 0; bus.s0_valid = 0; bus.s1_valid = 0;
    @(negedge clk);
    check("vec_rf_we", bus.rf_we, v.exp_we);
    check("vec_rf_swap", bus.rf_swap, v.exp_swap);
    check("vec_busy_t1", bus.busy, 1);
    if (v.exp_we) begin
      check("vec_addr_w", bus.rf_address_w, v.waddr);
      check("vec_data_w", bus.rf_data_w, v.wdata);
    end
    for (int k = 1; k <= limit; k++) begin
      if (k > 1) begin
        @(posedge clk);
        @(negedge clk);
        if (bus.rf_we || bus.rf_swap) extra++;
        if (k == 2 && v.exp_we) check("vec_busy_wr_end", bus.busy, 0);
      end
      if (v.exp_swap) begin
        check("vec_addr_A", bus.rf_address_A, v.a);
        check("vec_addr_B", bus.rf_address_B, v.b);
      end
      if (bus.done) begin
        got = k; gid = bus.done_id; gerr = bus.done_err;
        break;
      end
    end
    check("vec_done_lat", got, v.exp_lat);
    if (v.exp_lat != 0) begin
      check("vec_done_id", gid, v.exp_id);
      check("vec_done_err", gerr, v.exp_err);
    end
    check("vec_no_extra_rf_op", extra, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order[6];
    int nacc, ndone, win, ptr_m, free_at;
    logic [2:0] r;
    logic [AW-1:0] m_waddr, m_a, m_b;
    logic [DW-1:0] m_wdata;

    vecs[0] = mk(1, 0, 0, 7'd0,   7'd0,  7'd5, 8'hA5, 3'b001, 1, 0, 0, 0, 0);
    vecs[1] = mk(0, 1, 0, 7'd3,   7'd9,  7'd0, 8'h00, 3'b010, 0, 1, LAT + 1, 0, 0);
    vecs[2] = mk(0, 0, 1, 7'd7,   7'd7,  7'd0, 8'h00, 3'b100, 0, 0, 1, 1, 1);
    vecs[3] = mk(0, 1, 0, 7'd0,   7'd4,  7'd0, 8'h00, 3'b010, 0, 0, 1, 1, 0);
    vecs[4] = mk(0, 0, 1, 7'd12,  7'd0,  7'd0, 8'h00, 3'b100, 0, 0, 1, 1, 1);
    vecs[5] = mk(0, 0, 1, 7'd21,  7'd42, 7'd0, 8'h00, 3'b100, 0, 1, LAT + 1, 0, 1);
    vecs[6] = mk(1, 0, 0, 7'd0,   7'd0,  7'd0, 8'h3C, 3'b001, 1, 0, 0, 0, 0);
    vecs[7] = mk(0, 1, 0, 7'd127, 7'd1,  7'd0, 8'h00, 3'b010, 0, 1, LAT + 1, 0, 0);
    vecs[8] = mk(0, 1, 0, 7'd0,   7'd0,  7'd0, 8'h00, 3'b010, 0, 0, 1, 1, 0);

    // Reset state, with every requester asserting valid.
    reset_n = 0;
    idle_inputs();
    bus.wr_valid = 1; bus.wr_addr = 7'd5; bus.wr_data = 8'hA5;
    bus.s0_valid = 1; bus.s0_addr_a = 7'd3;  bus.s0_addr_b = 7'd9;
    bus.s1_valid = 1; bus.s1_addr_a = 7'd10; bus.s1_addr_b = 7'd20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {bus.s1_ready, bus.s0_ready, bus.wr_ready}, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rf_we", bus.rf_we, 0);
    check("rst_rf_swap", bus.rf_swap, 0);
    check("rst_done", {bus.done, bus.done_id, bus.done_err}, 0);
    check("rst_addrs", {bus.rf_address_w, bus.rf_data_w, bus.rf_address_A, bus.rf_address_B}, 0);

    // Round-robin with all three valids held from reset.
    @(posedge clk); #1 reset_n = 1;
    nacc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      r = {bus.s1_ready, bus.s0_ready, bus.wr_ready};
      if (r != 0) begin
        check("rr_accept_only_idle", bus.busy, 0);
        check("rr_onehot", $onehot(r), 1);
        if (nacc < 6) order[nacc] = r[0] ? 0 : (r[1] ? 1 : 2);
        nacc++;
      end
      @(posedge clk);
    end
    check("rr_enough_accepts", (nacc >= 6), 1);
    for (int i = 0; i < 6; i++) check("rr_order", order[i], i % 3);

    // Directed vectors.
    do_reset();
    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a legal swap.
    do_reset();
    @(posedge clk); #1;
    bus.s0_valid = 1; bus.s0_addr_a = 7'd3; bus.s0_addr_b = 7'd9;
    @(negedge clk);
    check("mid_ready", bus.s0_ready, 1);
    @(posedge clk); #1 bus.s0_valid = 0;
    @(posedge clk); #1;
    reset_n = 0;
    bus.s0_valid = 1;
    #1;
    check("mid_rst_ready", bus.s0_ready, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ctrl", {bus.rf_we, bus.rf_swap, bus.done, bus.done_id, bus.done_err}, 0);
    check("mid_rst_addrs", {bus.rf_address_A, bus.rf_address_B, bus.rf_address_w, bus.rf_data_w}, 0);
    bus.s0_valid = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    check("mid_no_done", ndone, 0);
    check("mid_idle", bus.busy, 0);
    run_vec(vecs[1]);

    // Random traffic against a transaction-level model.
    do_reset();
    for (int i = 0; i < 1024; i++) begin
      e_we[i] = 0; e_swap[i] = 0; e_done[i] = 0; e_busy[i] = 0; e_id[i] = 0; e_err[i] = 0;
    end
    ptr_m = 0; free_at = 0; rv = '0;
    m_waddr = '0; m_wdata = '0; m_a = '0; m_b = '0;
    for (int n = 0; n < NR; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      for (int j = 0; j < 3; j++) begin
        if (!rv[j] && $urandom_range(0, 2) == 0) begin
          rv[j] = 1;
          ra[j] = 7'($urandom_range(0, (j == 0) ? 127 : 7));
          rb[j] = 7'($urandom_range(0, 7));
          rd[j] = 8'($urandom);
        end
      end
      bus.wr_valid = rv[0]; bus.wr_addr = ra[0]; bus.wr_data = rd[0];
      bus.s0_valid = rv[1]; bus.s0_addr_a = ra[1]; bus.s0_addr_b = rb[1];
      bus.s1_valid = rv[2]; bus.s1_addr_a = ra[2]; bus.s1_addr_b = rb[2];
      @(negedge clk);
      win = -1;
      if (n >= free_at)
        for (int i = 0; i < 3; i++)
          if (win < 0 && rv[(ptr_m + i) % 3]) win = (ptr_m + i) % 3;
      check("m_ready", {bus.s1_ready, bus.s0_ready, bus.wr_ready}, (win < 0) ? 0 : (1 << win));
      check("m_rf_we", bus.rf_we, e_we[n]);
      check("m_rf_swap", bus.rf_swap, e_swap[n]);
      check("m_done", bus.done, e_done[n]);
      check("m_busy", bus.busy, e_busy[n]);
      if (e_done[n]) begin
        check("m_done_id", bus.done_id, e_id[n]);
        check("m_done_err", bus.done_err, e_err[n]);
      end
      check("m_addr_w", bus.rf_address_w, m_waddr);
      check("m_data_w", bus.rf_data_w, m_wdata);
      check("m_addr_A", bus.rf_address_A, m_a);
      check("m_addr_B", bus.rf_address_B, m_b);
      if (win >= 0) begin
        ptr_m = (win + 1) % 3;
        rv[win] = 0;
        if (win == 0) begin
          e_we[n + 1] = 1; e_busy[n + 1] = 1; free_at = n + 2;
          m_waddr = ra[0]; m_wdata = rd[0];
        end else if (ra[win] != rb[win] && ra[win] != 0 && rb[win] != 0) begin
          e_swap[n + 1] = 1;
          for (int k = 1; k <= LAT + 1; k++) e_busy[n + k] = 1;
          e_done[n + LAT + 1] = 1; e_id[n + LAT + 1] = (win == 2); e_err[n + LAT + 1] = 0;
          free_at = n + LAT + 2;
          m_a = ra[win]; m_b = rb[win];
        end else begin
          e_busy[n + 1] = 1; e_done[n + 1] = 1; e_id[n + 1] = (win == 2); e_err[n + 1] = 1;
          free_at = n + 2;
        end
      end
    end
    idle_inputs();

`ifdef SWAP_SCHED_PERF_EN
    do_reset();
    #1;
    check("perf_swap_rst", swap_count, 0);
    check("perf_err_rst", err_count, 0);
    run_vec(vecs[1]);
    run_vec(vecs[2]);
    run_vec(vecs[5]);
    run_vec(vecs[3]);
    run_vec(vecs[7]);
    @(negedge clk);
    check("perf_swap_count", swap_count, 3);
    check("perf_err_count", err_count, 2);
    do_reset();
    #1;
    check("perf_swap_after_rst", swap_count, 0);
    check("perf_err_after_rst", err_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
